// File: rtl/enc_pkg.sv
// Shared constants and state type for the encryption stream controller.
package enc_pkg;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_ENC  = 2'b10;
  localparam logic [7:0] NUL_CHAR  = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT,
    DONE
  } enc_ctrl_state_t;

endpackage

// File: rtl/encryption_stream_ctrl.sv
// Feeds one plaintext char at a time into the encryption core and returns
// ciphertext (or an error beat) on a valid/ready stream.
module encryption_stream_ctrl
  import enc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       key_in,
  output logic             busy,
  input  logic             ptxt_valid,
  input  logic [7:0]       ptxt_data,
  input  logic             ptxt_last,
  output logic             ptxt_ready,
  output logic             ctxt_valid,
  output logic [7:0]       ctxt_data,
  output logic             ctxt_last,
  output logic             ctxt_err,
  input  logic             ctxt_ready,
  output logic [1:0]       core_mode,
  output logic [7:0]       core_plaintext,
  output logic [7:0]       core_public_key,
  input  logic [7:0]       core_ciphertext,
  input  logic             core_c_ready,
  input  logic             core_err,
  output logic             msg_done,
  output logic [CNT_W-1:0] char_count,
  output logic [CNT_W-1:0] err_count,
  output logic             timeout_flag
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  enc_ctrl_state_t state_q, state_d;
  logic [7:0]       key_q, key_d;
  logic [7:0]       data_q, data_d;
  logic             last_q, last_d;
  logic [7:0]       ctxt_q, ctxt_d;
  logic             err_q, err_d;
  logic             tmo_q, tmo_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] char_cnt_q, char_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      key_q      <= 8'h00;
      data_q     <= 8'h00;
      last_q     <= 1'b0;
      ctxt_q     <= 8'h00;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
      timer_q    <= '0;
      char_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      data_q     <= data_d;
      last_q     <= last_d;
      ctxt_q     <= ctxt_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      timer_q    <= timer_d;
      char_cnt_q <= char_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    data_d     = data_q;
    last_d     = last_q;
    ctxt_d     = ctxt_q;
    err_d      = err_q;
    tmo_d      = tmo_q;
    timer_d    = timer_q;
    char_cnt_d = char_cnt_q;
    err_cnt_d  = err_cnt_q;
    ptxt_ready = 1'b0;
    ctxt_valid = 1'b0;
    msg_done   = 1'b0;
    core_mode  = MODE_IDLE;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d      = key_in;
          char_cnt_d = '0;
          err_cnt_d  = '0;
          tmo_d      = 1'b0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        ptxt_ready = 1'b1;
        if (ptxt_valid) begin
          data_d    = ptxt_data;
          last_d    = ptxt_last;
          core_mode = MODE_ENC;
          timer_d   = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        core_mode = MODE_ENC;
        timer_d   = timer_q + TW'(1);
        // Core error outranks a simultaneous C_ready.
        if (core_err) begin
          ctxt_d  = NUL_CHAR;
          err_d   = 1'b1;
          state_d = OUT;
        end else if (core_c_ready) begin
          ctxt_d  = core_ciphertext;
          err_d   = 1'b0;
          state_d = OUT;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          ctxt_d  = NUL_CHAR;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        ctxt_valid = 1'b1;
        if (ctxt_ready) begin
          if (char_cnt_q != '1) char_cnt_d = char_cnt_q + CNT_W'(1);
          if (err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
          state_d = last_q ? DONE : ISSUE;
        end
      end
      DONE: begin
        msg_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy            = (state_q == ISSUE) || (state_q == WAIT) || (state_q == OUT);
  assign core_plaintext  = (state_q == ISSUE && ptxt_valid) ? ptxt_data : data_q;
  assign core_public_key = key_q;
  assign ctxt_data       = ctxt_q;
  assign ctxt_last       = ctxt_valid & last_q;
  assign ctxt_err        = ctxt_valid & err_q;
  assign char_count      = char_cnt_q;
  assign err_count       = err_cnt_q;
  assign timeout_flag    = tmo_q;

endmodule

// File: tb/tb_encryption_stream_ctrl.sv
// Bench for encryption_stream_ctrl with a behavioural encryption-core model.
module tb_encryption_stream_ctrl;

  logic        clk, rst, start, busy;
  logic [7:0]  key_in;
  logic        ptxt_valid, ptxt_last, ptxt_ready;
  logic [7:0]  ptxt_data;
  logic        ctxt_valid, ctxt_last, ctxt_err, ctxt_ready;
  logic [7:0]  ctxt_data;
  logic [1:0]  core_mode;
  logic [7:0]  core_plaintext, core_public_key, core_ciphertext;
  logic        core_c_ready, core_err, msg_done, timeout_flag;
  logic [15:0] char_count, err_count;

  encryption_stream_ctrl #(.TIMEOUT_CYC(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy),
    .ptxt_valid(ptxt_valid), .ptxt_data(ptxt_data), .ptxt_last(ptxt_last),
    .ptxt_ready(ptxt_ready), .ctxt_valid(ctxt_valid), .ctxt_data(ctxt_data),
    .ctxt_last(ctxt_last), .ctxt_err(ctxt_err), .ctxt_ready(ctxt_ready),
    .core_mode(core_mode), .core_plaintext(core_plaintext),
    .core_public_key(core_public_key), .core_ciphertext(core_ciphertext),
    .core_c_ready(core_c_ready), .core_err(core_err), .msg_done(msg_done),
    .char_count(char_count), .err_count(err_count), .timeout_flag(timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int done_seen = 0;
  bit mute = 1'b0;
  bit both = 1'b0;
  logic [7:0] pt[8];
  int n_ch, stall_at, stall_len, mute_at, both_at;
  bit poke_start;

  // Core model: 2-cycle latency, XOR cipher, error on non-ASCII plaintext.
  logic [1:0] cm_cnt;
  logic       cm_busy, cm_hold;
  logic [7:0] cm_pt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cm_cnt <= 0; cm_busy <= 0; cm_hold <= 0; cm_pt <= 0;
      core_c_ready <= 0; core_err <= 0; core_ciphertext <= 0;
    end else begin
      core_c_ready <= 0;
      core_err     <= 0;
      if (cm_hold) begin
        if (core_mode != 2'b10) cm_hold <= 0;
      end else if (cm_busy) begin
        if (cm_cnt == 2'd1) begin
          cm_busy <= 0;
          cm_hold <= 1;
          core_ciphertext <= cm_pt ^ core_public_key;
          if (!mute) begin
            if (both) begin
              core_c_ready <= 1; core_err <= 1;
            end else if (cm_pt > 8'h7F) core_err <= 1;
            else core_c_ready <= 1;
          end
        end else cm_cnt <= cm_cnt - 2'd1;
      end else if (core_mode == 2'b10) begin
        cm_busy <= 1; cm_cnt <= 2'd2; cm_pt <= core_plaintext;
      end
    end
  end

  always @(negedge clk) if (msg_done) done_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed hang, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic run_msg(input logic [7:0] key);
    int n;
    int errs;
    bit tmo, expe;
    logic [7:0] expd;
    errs = 0; tmo = 0;
    @(negedge clk); start = 1; key_in = key;
    @(negedge clk); start = 0; key_in = 8'($urandom);
    check("busy_after_start", busy, 1);
    for (int i = 0; i < n_ch; i++) begin
      mute = (i == mute_at); both = (i == both_at);
      ptxt_valid = 1; ptxt_data = pt[i]; ptxt_last = (i == n_ch - 1);
      n = 0;
      while (!ptxt_ready && n < 50) begin @(negedge clk); n++; end
      check("ptxt_ready_seen", n < 50, 1);
      @(negedge clk);
      ptxt_valid = 0; ptxt_data = 8'($urandom); ptxt_last = 0;
      check("core_mode_enc", core_mode, 2'b10);
      check("core_key_wait", core_public_key, key);
      check("no_ready_in_wait", ptxt_ready, 0);
      n = 0;
      while (!ctxt_valid && n < 50) begin @(negedge clk); n++; end
      check("beat_seen", n < 50, 1);
      if (mute) check("timeout_latency", n, 16);
      expe = mute || both || (pt[i] > 8'h7F);
      expd = expe ? 8'h00 : (pt[i] ^ key);
      if (expe) errs++;
      if (mute) tmo = 1;
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          check("stall_data_held", ctxt_data, expd);
          check("stall_valid_held", ctxt_valid, 1);
          check("stall_no_ptxt_ready", ptxt_ready, 0);
          @(negedge clk);
        end
      end
      check("core_mode_idle_out", core_mode, 2'b00);
      ctxt_ready = 1;
      check("ctxt_data", ctxt_data, expd);
      check("ctxt_err", ctxt_err, expe);
      check("ctxt_last", ctxt_last, (i == n_ch - 1));
      @(negedge clk);
      ctxt_ready = 0;
      if (poke_start && i == 0 && n_ch > 1) begin
        start = 1; key_in = ~key;
        @(negedge clk);
        start = 0;
        check("busy_ignores_start", busy, 1);
      end
    end
    mute = 0; both = 0;
    check("msg_done_pulse", msg_done, 1);
    check("busy_done", busy, 0);
    check("char_count", char_count, n_ch);
    check("err_count", err_count, errs);
    check("timeout_flag", timeout_flag, tmo);
    @(negedge clk);
    check("msg_done_one_cycle", msg_done, 0);
    check("count_hold", char_count, n_ch);
  endtask

  task automatic clear_opts();
    stall_at = -1; stall_len = 0; mute_at = -1; both_at = -1; poke_start = 0;
  endtask

  initial begin
    int d0;
    rst = 1; start = 0; key_in = 0; ptxt_valid = 0; ptxt_data = 0; ptxt_last = 0;
    ctxt_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ptxt_ready", ptxt_ready, 0);
    check("rst_ctxt_valid", ctxt_valid, 0);
    check("rst_ctxt_data", ctxt_data, 0);
    check("rst_char_count", char_count, 0);
    check("rst_err_count", err_count, 0);
    check("rst_timeout", timeout_flag, 0);
    check("rst_core_mode", core_mode, 0);
    check("rst_core_key", core_public_key, 0);
    check("rst_msg_done", msg_done, 0);
    rst = 0;
    @(negedge clk);

    // Key C8, "AB" with a 10-cycle sink stall and an ignored start mid-message.
    clear_opts(); n_ch = 2; pt[0] = 8'h41; pt[1] = 8'h42;
    stall_at = 0; stall_len = 10; poke_start = 1;
    run_msg(8'hC8);
    check("done_count_1", done_seen, 1);

    // Non-ASCII char mid-message.
    clear_opts(); n_ch = 3; pt[0] = 8'h10; pt[1] = 8'hFF; pt[2] = 8'h33;
    run_msg(8'h5A);

    // Core never answers on the middle char.
    clear_opts(); n_ch = 3; pt[0] = 8'h20; pt[1] = 8'h21; pt[2] = 8'h22; mute_at = 1;
    run_msg(8'h0F);

    // Error and C_ready together.
    clear_opts(); n_ch = 2; pt[0] = 8'h61; pt[1] = 8'h62; both_at = 1;
    run_msg(8'h33);

    // Reset while waiting on the core.
    clear_opts(); mute = 1;
    @(negedge clk); start = 1; key_in = 8'hA5;
    @(negedge clk); start = 0;
    ptxt_valid = 1; ptxt_data = 8'h44; ptxt_last = 1;
    @(negedge clk); ptxt_valid = 0; ptxt_last = 0;
    repeat (3) @(negedge clk);
    check("pre_rst_wait", core_mode, 2'b10);
    d0 = done_seen;
    rst = 1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_core_mode", core_mode, 0);
    check("midrst_ctxt_valid", ctxt_valid, 0);
    check("midrst_core_key", core_public_key, 0);
    rst = 0; mute = 0;
    repeat (20) @(negedge clk);
    check("midrst_no_done", done_seen, d0);
    check("midrst_idle", busy, 0);
    clear_opts(); n_ch = 2; pt[0] = 8'h4B; pt[1] = 8'h4C;
    run_msg(8'h99);

    // Random messages.
    for (int m = 0; m < 8; m++) begin
      clear_opts();
      n_ch = int'($urandom_range(1, 6));
      for (int i = 0; i < n_ch; i++) pt[i] = 8'($urandom);
      stall_at = int'($urandom_range(0, n_ch - 1));
      stall_len = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) mute_at = int'($urandom_range(0, n_ch - 1));
      if ($urandom_range(0, 3) == 0) both_at = int'($urandom_range(0, n_ch - 1));
      run_msg(8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
